// File: rtl/operand_buffer.sv
// Double-buffered 2x2 operand store feeding mmu_feeder: host bytes fill the shadow bank while the active bank drives the outputs.
// Optional rewrite protection (drop writes to already-written slots) is enabled by defining OPERAND_BUF_REWRITE_PROTECT_EN.
module operand_buffer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic [2:0]        addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              swap,
  output logic [DATA_W-1:0] weight0,
  output logic [DATA_W-1:0] weight1,
  output logic [DATA_W-1:0] weight2,
  output logic [DATA_W-1:0] weight3,
  output logic [DATA_W-1:0] input0,
  output logic [DATA_W-1:0] input1,
  output logic [DATA_W-1:0] input2,
  output logic [DATA_W-1:0] input3,
  output logic              shadow_full,
  output logic              active_valid,
  output logic              swap_err,
  output logic              wr_conflict
);

  logic [DATA_W-1:0] bank  [2][8];
  logic [DATA_W-1:0] act_q [8];
  logic              bank_sel;
  logic [7:0]        mask;
  logic [7:0]        mask_next;
  logic              swap_ok;
  logic              wr_bank;
  logic              wr_do;
  logic              conflict;

  // A write coincident with an accepted swap targets the new shadow and sees a cleared mask.
  always_comb begin
    swap_ok  = swap & shadow_full;
    wr_bank  = swap_ok ? ~bank_sel : bank_sel;
    conflict = 1'b0;
`ifdef OPERAND_BUF_REWRITE_PROTECT_EN
    conflict = write_en & ~swap_ok & mask[addr];
`endif
    wr_do     = write_en & ~conflict;
    mask_next = swap_ok ? 8'h00 : mask;
    if (wr_do) mask_next[addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 8; i++)
          bank[b][i] <= '0;
      for (int i = 0; i < 8; i++)
        act_q[i] <= '0;
      bank_sel     <= 1'b0;
      mask         <= 8'h00;
      shadow_full  <= 1'b0;
      active_valid <= 1'b0;
      swap_err     <= 1'b0;
    end else begin
      if (wr_do) bank[wr_bank][addr] <= in_data;
      if (swap_ok) begin
        bank_sel     <= ~bank_sel;
        active_valid <= 1'b1;
        for (int i = 0; i < 8; i++)
          act_q[i] <= bank[bank_sel][i];
      end
      mask        <= mask_next;
      shadow_full <= &mask_next;
      swap_err    <= swap & ~shadow_full;
    end
  end

`ifdef OPERAND_BUF_REWRITE_PROTECT_EN
  logic conflict_q;

  always_ff @(posedge clk) begin
    if (rst) conflict_q <= 1'b0;
    else     conflict_q <= conflict;
  end

  assign wr_conflict = conflict_q;
`else
  assign wr_conflict = 1'b0;
`endif

  assign weight0 = act_q[0];
  assign weight1 = act_q[1];
  assign weight2 = act_q[2];
  assign weight3 = act_q[3];
  assign input0  = act_q[4];
  assign input1  = act_q[5];
  assign input2  = act_q[6];
  assign input3  = act_q[7];

endmodule

// File: tb/tb_operand_buffer.sv
// Directed bench for operand_buffer: expected operand sets are queued when a swap (or reset) is driven
// and popped when the outputs are sampled one cycle later.
module tb_operand_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       write_en = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] in_data = 8'h00;
  logic       swap = 1'b0;
  logic [7:0] weight0, weight1, weight2, weight3;
  logic [7:0] input0, input1, input2, input3;
  logic       shadow_full, active_valid, swap_err, wr_conflict;

  int passed = 0;
  int total  = 0;
  logic [63:0] exp_q[$];

  operand_buffer #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .addr(addr), .in_data(in_data), .swap(swap),
    .weight0(weight0), .weight1(weight1), .weight2(weight2), .weight3(weight3),
    .input0(input0), .input1(input1), .input2(input2), .input3(input3),
    .shadow_full(shadow_full), .active_valid(active_valid),
    .swap_err(swap_err), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

`ifdef OPERAND_BUF_REWRITE_PROTECT_EN
  localparam logic [7:0] EXP_W2       = 8'h01;
  localparam logic [7:0] EXP_CONFLICT = 8'h01;
`else
  localparam logic [7:0] EXP_W2       = 8'h02;
  localparam logic [7:0] EXP_CONFLICT = 8'h00;
`endif

  function automatic logic [63:0] mkSet(input logic [7:0] base, input logic [7:0] step);
    logic [63:0] s;
    for (int i = 0; i < 8; i++) s[8*i +: 8] = base + step * 8'(i);
    return s;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, sample 1 time unit after the edge.
  task automatic applyStimulus(input logic we, input logic [2:0] a, input logic [7:0] d, input logic sw);
    write_en = we; addr = a; in_data = d; swap = sw;
    @(posedge clk);
    #1;
    write_en = 1'b0; swap = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1; write_en = 1'b1; swap = 1'b1; addr = 3'd5; in_data = 8'hEE;
    @(posedge clk);
    #1;
    rst = 1'b0; write_en = 1'b0; swap = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    logic [63:0] exp, obs;
    if (exp_q.size() == 0) begin
      total++;
      $display("[TB] FAIL %s observed=empty_queue expected=queued_set", tag);
      return;
    end
    exp = exp_q.pop_front();
    obs = {input3, input2, input1, input0, weight3, weight2, weight1, weight0};
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_op%0d", tag, i), obs[8*i +: 8], exp[8*i +: 8]);
  endtask

  initial begin
    logic [63:0] set_a, set_b, set_c, set_d, set_e, set_f;
    set_a = mkSet(8'h11, 8'h11);
    set_b = mkSet(8'hA0, 8'h01);
    set_c = mkSet(8'hC0, 8'h01);
    set_d = mkSet(8'hD0, 8'h01);
    set_d[31:24] = 8'h5C;
    set_e = mkSet(8'hE0, 8'h01);
    set_e[23:16] = EXP_W2;
    set_f = mkSet(8'h60, 8'h01);

    doReset();
    exp_q.push_back(64'h0);
    checkOutput("reset");
    check("reset_valid", 8'(active_valid), 8'h00);
    check("reset_full", 8'(shadow_full), 8'h00);
    check("reset_err", 8'(swap_err), 8'h00);
    check("reset_conflict", 8'(wr_conflict), 8'h00);

    // Premature swap after six writes
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 3'(i), set_a[8*i +: 8], 1'b0);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
    exp_q.push_back(64'h0);
    checkOutput("premature");
    check("premature_err", 8'(swap_err), 8'h01);
    check("premature_valid", 8'(active_valid), 8'h00);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0);
    check("err_one_cycle", 8'(swap_err), 8'h00);
    applyStimulus(1'b1, 3'd6, set_a[55:48], 1'b0);
    check("full_after7", 8'(shadow_full), 8'h00);
    applyStimulus(1'b1, 3'd7, set_a[63:56], 1'b0);
    check("full_after8", 8'(shadow_full), 8'h01);
    exp_q.push_back(set_a);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
    checkOutput("swap_a");
    check("swap_a_valid", 8'(active_valid), 8'h01);
    check("swap_a_full", 8'(shadow_full), 8'h00);
    check("swap_a_err", 8'(swap_err), 8'h00);

    // Ping-pong: outputs hold set A while set B loads
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 3'(i), set_b[8*i +: 8], 1'b0);
      exp_q.push_back(set_a);
      checkOutput($sformatf("hold_a_%0d", i));
    end
    exp_q.push_back(set_b);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
    checkOutput("swap_b");

    // Coincident write with accepted swap
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(i), set_c[8*i +: 8], 1'b0);
    exp_q.push_back(set_c);
    applyStimulus(1'b1, 3'd3, 8'h5C, 1'b1);
    checkOutput("swap_c");
    check("coinc_full", 8'(shadow_full), 8'h00);
    check("coinc_conflict", 8'(wr_conflict), 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) continue;
      if (i == 7) check("coinc_full_before_last", 8'(shadow_full), 8'h00);
      applyStimulus(1'b1, 3'(i), set_d[8*i +: 8], 1'b0);
    end
    check("coinc_full_after7", 8'(shadow_full), 8'h01);
    exp_q.push_back(set_d);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
    checkOutput("swap_d");

    // Overwrite of addr 2
    applyStimulus(1'b1, 3'd2, 8'h01, 1'b0);
    check("ow_first_conflict", 8'(wr_conflict), 8'h00);
    applyStimulus(1'b1, 3'd2, 8'h02, 1'b0);
    check("ow_second_conflict", 8'(wr_conflict), EXP_CONFLICT);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) continue;
      applyStimulus(1'b1, 3'(i), set_e[8*i +: 8], 1'b0);
      if (i == 0) check("ow_conflict_cleared", 8'(wr_conflict), 8'h00);
    end
    check("ow_full", 8'(shadow_full), 8'h01);
    exp_q.push_back(set_e);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
    checkOutput("swap_e");

    // Reset mid-load with an active set present
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 3'(i), 8'h77, 1'b0);
    doReset();
    exp_q.push_back(64'h0);
    checkOutput("midload_rst");
    check("midload_valid", 8'(active_valid), 8'h00);
    check("midload_full", 8'(shadow_full), 8'h00);
    check("midload_err", 8'(swap_err), 8'h00);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(i), set_f[8*i +: 8], 1'b0);
    check("post_rst_full", 8'(shadow_full), 8'h01);
    exp_q.push_back(set_f);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
    checkOutput("swap_f");
    check("post_rst_valid", 8'(active_valid), 8'h01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
